// File: rtl/jstk_spi_responder_if.sv
// jstk_spi_responder_if: SPI pins between the paddle master and the joystick responder
interface jstk_spi_responder_if;
  logic cs;
  logic sck;
  logic mosi;
  logic miso;
  modport master (output cs, sck, mosi, input miso);
  modport slave (input cs, sck, mosi, output miso);
endinterface

// File: rtl/jstk_spi_responder.sv
// jstk_spi_responder: PMOD JSTK joystick emulator answering the 5-byte paddle SPI frame
module jstk_spi_responder (
  input  logic                       clk50M,
  input  logic                       reset,
  jstk_spi_responder_if.slave        spi,
  input  logic [9:0]                 x_pos,
  input  logic [9:0]                 y_pos,
  input  logic [2:0]                 buttons,
  output logic [1:0]                 led,
  output logic                       frame_done,
  output logic [7:0]                 frame_count
);
  typedef enum logic [1:0] {IDLE, SHIFT, OVERRUN} state_t;
  state_t state_q, state_d;
  // [0],[1] synchronizer flops, [2] previous synchronized value for edge detect
  logic [2:0] cs_sync_q, cs_sync_d, sck_sync_q, sck_sync_d;
  logic [1:0] mosi_sync_q, mosi_sync_d;
  logic [39:0] tx_q, tx_d;
  logic [7:0] rx_q, rx_d, rx_next;
  logic [5:0] cnt_q, cnt_d;
  logic [1:0] led_q, led_d;
  logic done_q, done_d;
  logic [7:0] fcnt_q, fcnt_d;
  logic cs_fall, cs_rise, sck_rise, sck_fall, load, rise_sh, last;
  always_comb begin
    cs_sync_d = {cs_sync_q[1:0], spi.cs};
    sck_sync_d = {sck_sync_q[1:0], spi.sck};
    mosi_sync_d = {mosi_sync_q[0], spi.mosi};
    cs_fall = cs_sync_q[2] & ~cs_sync_q[1];
    cs_rise = ~cs_sync_q[2] & cs_sync_q[1];
    sck_rise = ~sck_sync_q[2] & sck_sync_q[1];
    sck_fall = sck_sync_q[2] & ~sck_sync_q[1];
    load = (state_q == IDLE) & cs_fall;
    rise_sh = (state_q == SHIFT) & sck_rise;
    last = rise_sh & (cnt_q == 6'd39);
  end
  always_ff @(posedge clk50M or negedge reset)
    if (!reset) state_q <= IDLE;
    else state_q <= state_d;
  always_comb
    state_d = cs_rise ? IDLE : load ? SHIFT : last ? OVERRUN : state_q;
  always_comb begin
    rx_next = {rx_q[6:0], mosi_sync_q[1]};
    tx_d = load ? {x_pos[7:0], 6'b0, x_pos[9:8], y_pos[7:0], 6'b0, y_pos[9:8], 5'b0, buttons}
         : ((state_q == SHIFT) & sck_fall) ? {tx_q[38:0], 1'b0} : tx_q;
    rx_d = load ? 8'd0 : rise_sh ? rx_next : rx_q;
    cnt_d = load ? 6'd0 : rise_sh ? cnt_q + 6'd1 : cnt_q;
    // only the first byte carries a command; 100000xx sets the LEDs
    led_d = (rise_sh & (cnt_q == 6'd7) & (rx_next[7:2] == 6'b100000)) ? rx_next[1:0] : led_q;
    done_d = last;
    fcnt_d = fcnt_q + {7'd0, last};
  end
  always_ff @(posedge clk50M or negedge reset)
    if (!reset) begin
      cs_sync_q <= 3'b111;
      sck_sync_q <= 3'b000;
      mosi_sync_q <= 2'b00;
      tx_q <= '0;
      rx_q <= '0;
      cnt_q <= '0;
      led_q <= '0;
      done_q <= 1'b0;
      fcnt_q <= '0;
    end else begin
      cs_sync_q <= cs_sync_d;
      sck_sync_q <= sck_sync_d;
      mosi_sync_q <= mosi_sync_d;
      tx_q <= tx_d;
      rx_q <= rx_d;
      cnt_q <= cnt_d;
      led_q <= led_d;
      done_q <= done_d;
      fcnt_q <= fcnt_d;
    end
  always_comb begin
    spi.miso = (state_q == SHIFT) & tx_q[39];
    led = led_q;
    frame_done = done_q;
    frame_count = fcnt_q;
  end
endmodule
